otg_hpi_access_ctrl: RTL and testbench
======================================

Name: otg_hpi_access_ctrl

Overview:
Avalon-MM slave that sequences single 16-bit accesses to the CY7C67200 OTG controller's Host Port Interface (HPI).
- Converts one Avalon read/write into a timed HPI cycle: cs_n, addr, rd_n/wr_n, tri-state data.
- Holds the master with waitrequest until the cycle completes.
- Enforces setup/strobe/hold/recovery timing set by parameters.
- Sits between the Nios II data master and the OTG chip pins; replaces software bit-banging of the chip-select and strobe PIOs.

Parameters:
- SETUP_CYC, 2: cycles cs_n/addr/data valid before strobe falls; legal range 1..15.
- STROBE_CYC, 4: cycles rd_n/wr_n held low; legal range 1..15.
- HOLD_CYC, 2: cycles cs_n/addr/data held after strobe rises; legal range 1..15.
- RECOV_CYC, 3: cycles cs_n high before the next access may start; legal range 0..15.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  HPI register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  16  write data.
- avs_readdata  out  16  read data; valid in the cycle waitrequest is low for a read.
- avs_waitrequest  out  1  stall to master.
- otg_addr  out  2  HPI address pins.
- otg_cs_n  out  1  HPI chip select, active low.
- otg_rd_n  out  1  HPI read strobe, active low.
- otg_wr_n  out  1  HPI write strobe, active low.
- otg_data_out  out  16  data driven to the pad.
- otg_data_oe  out  1  pad output enable; the top level builds the tri-state.
- otg_data_in  in  16  data from the pad.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE; otg_cs_n=1, otg_rd_n=1, otg_wr_n=1; otg_addr=0; otg_data_out=0; otg_data_oe=0; avs_readdata=0.
- Reset mid-access: all strobes return high and oe goes low immediately (asynchronous). No partial transaction is retried.
- Outputs: all otg_* outputs are registered. No combinational path from avs_* to the pins.
- request = avs_chipselect & (avs_read | avs_write). If read and write are both high, the access is a write.
- avs_waitrequest = request & ~done. done is high only in the final HOLD cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOV. A down-counter cnt[3:0] is loaded with N-1 on entry to each timed state.
- IDLE: on request, latch addr/rw/writedata and go to SETUP. Pins in the next cycle: cs_n=0, addr valid, oe=1 if write.
- SETUP (SETUP_CYC cycles): rd_n=1, wr_n=1. When cnt=0, go to STROBE.
- STROBE (STROBE_CYC cycles): rd_n=0 for reads, wr_n=0 for writes. On the clock edge ending the last STROBE cycle, otg_data_in is captured into avs_readdata (reads only).
- HOLD (HOLD_CYC cycles): strobes=1; cs_n, addr and data stay as they were. In the last HOLD cycle done=1, so waitrequest is low for exactly one cycle.
- After HOLD: go to RECOV if RECOV_CYC>0, otherwise to IDLE.
- RECOV (RECOV_CYC cycles): cs_n=1, oe=0. A pending request sees waitrequest=1 and is not accepted.
- Back-to-back with RECOV_CYC=0: a request present in the IDLE cycle after HOLD is accepted, with cs_n high for one cycle between accesses.
- Total waitrequest-high cycles per access, counted from the request cycle: 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC - 1. The master sees done in the next cycle. Defaults: 8 high cycles, response in the 9th cycle.
- Write data, address and rw are latched at accept. Master changes during waitrequest are ignored. The master must hold the request per Avalon rules; dropping it mid-access does not abort the pin sequence.
- avs_readdata holds its value until the next read completes.

Decomposition:
- Package otg_hpi_pkg holds:
  - state enum {IDLE, SETUP, STROBE, HOLD, RECOV};
  - register-index constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDR=2, HPI_STATUS=3;
  - counter width constant CNT_W=4.
- No sub-module is needed; a single FSM plus counter is sufficient.

Test Plan:
- Reset: hold reset_n=0, then release; also assert reset_n=0 during STROBE of a write -> cs_n=1, rd_n=1, wr_n=1, oe=0 immediately; readdata=0; FSM returns to IDLE.
- Write, default params: write addr=2 data=0x1234 in cycle 0 -> cs_n=0 in cycles 1-8; wr_n=0 in cycles 3-6; otg_addr=2 and oe=1 with data_out=0x1234 in cycles 1-8; waitrequest low in cycle 8 only; cs_n=1 in cycle 9.
- Read: read addr=0, otg_data_in=0xBEEF during STROBE -> rd_n=0 in cycles 3-6; oe=0 throughout; readdata=0xBEEF in cycle 8 with waitrequest=0.
- Back-to-back: write then immediate read -> second access's cs_n does not fall before cycle 12 (RECOV cycles 9-11); waitrequest stays high through RECOV.
- Parameter corners: SETUP=1, STROBE=1, HOLD=1, RECOV=0 -> write completes with waitrequest low in cycle 3; next access cs_n falls in cycle 5.
- Illegal read&write, then change writedata mid-access: read=write=1 with data 0x00FF -> treated as write, wr_n toggles, rd_n stays 1; changing avs_writedata to 0xAAAA mid-access -> otg_data_out stays 0x00FF.

Source files
------------

// File: rtl/otg_hpi_pkg.sv
// otg_hpi_pkg: shared state type, HPI register indices and counter width for the HPI access controller
package otg_hpi_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} hpi_state_t;

endpackage

// File: rtl/otg_hpi_access_ctrl.sv
// otg_hpi_access_ctrl: turns one Avalon-MM access into a timed CY7C67200 HPI pin cycle
module otg_hpi_access_ctrl
    import otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RECOV_CYC  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC > 0 ? RECOV_CYC - 1 : 0);

    hpi_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             is_wr, wr_nx, busy_nx;
    logic             request, accept, done;
    logic             cs_n_nx, rd_n_nx, wr_n_nx, oe_nx;

    assign request         = avs_chipselect & (avs_read | avs_write);
    assign accept          = (state == IDLE) & request;
    assign done            = (state == HOLD) & (cnt == '0);
    assign avs_waitrequest = request & ~done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - 1'b1;
        case (state)
            IDLE: begin
                state_nx = request ? SETUP : IDLE;
                cnt_nx   = request ? SETUP_LD : cnt;
            end
            SETUP:  if (cnt == '0) begin state_nx = STROBE; cnt_nx = STROBE_LD; end
            STROBE: if (cnt == '0) begin state_nx = HOLD; cnt_nx = HOLD_LD; end
            HOLD:   if (cnt == '0) begin state_nx = (RECOV_CYC > 0) ? RECOV : IDLE; cnt_nx = RECOV_LD; end
            RECOV:  if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pin values for the coming cycle, registered below so the pads never see avs_* combinationally
    always_comb begin
        busy_nx = state_nx inside {SETUP, STROBE, HOLD};
        wr_nx   = accept ? avs_write : is_wr;
        cs_n_nx = ~busy_nx;
        oe_nx   = busy_nx & wr_nx;
        rd_n_nx = ~((state_nx == STROBE) & ~wr_nx);
        wr_n_nx = ~((state_nx == STROBE) & wr_nx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_wr        <= 1'b0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            otg_addr     <= '0;
            otg_data_out <= '0;
            avs_readdata <= '0;
        end else begin
            otg_cs_n    <= cs_n_nx;
            otg_rd_n    <= rd_n_nx;
            otg_wr_n    <= wr_n_nx;
            otg_data_oe <= oe_nx;
            if (accept) begin
                is_wr        <= avs_write;
                otg_addr     <= avs_address;
                otg_data_out <= avs_writedata;
            end
            if ((state == STROBE) && (cnt == '0) && !is_wr)
                avs_readdata <= otg_data_in;
        end
    end

endmodule

// File: tb/tb_otg_hpi_access_ctrl.sv
// tb_otg_hpi_access_ctrl: default and minimum-timing instances checked against a cycle-offset model
module tb_otg_hpi_access_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        cs[2], rd[2], wr[2], wt[2], cs_n[2], rd_n[2], wr_n[2], oe[2];
    logic [1:0]  ad[2], oa[2];
    logic [15:0] wd[2], din[2], rdata[2], dout[2];

    int ps[2] = '{2, 1};
    int pt[2] = '{4, 1};
    int ph[2] = '{2, 1};
    int pr[2] = '{3, 0};

    int checks = 0;
    int failures = 0;

    otg_hpi_access_ctrl dut0 (
        .clk(clk), .reset_n(reset_n), .avs_address(ad[0]), .avs_chipselect(cs[0]),
        .avs_read(rd[0]), .avs_write(wr[0]), .avs_writedata(wd[0]), .avs_readdata(rdata[0]),
        .avs_waitrequest(wt[0]), .otg_addr(oa[0]), .otg_cs_n(cs_n[0]), .otg_rd_n(rd_n[0]),
        .otg_wr_n(wr_n[0]), .otg_data_out(dout[0]), .otg_data_oe(oe[0]), .otg_data_in(din[0])
    );

    otg_hpi_access_ctrl #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOV_CYC(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .avs_address(ad[1]), .avs_chipselect(cs[1]),
        .avs_read(rd[1]), .avs_write(wr[1]), .avs_writedata(wd[1]), .avs_readdata(rdata[1]),
        .avs_waitrequest(wt[1]), .otg_addr(oa[1]), .otg_cs_n(cs_n[1]), .otg_rd_n(rd_n[1]),
        .otg_wr_n(wr_n[1]), .otg_data_out(dout[1]), .otg_data_oe(oe[1]), .otg_data_in(din[1])
    );

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, i, $time, act, exp);
        end
    endtask

    // model: an access occupies cycles 1..S+T+H after the accept cycle, then R blocked cycles
    logic        m_act[2], m_rw[2];
    int          m_k[2], m_blk[2];
    logic [1:0]  m_a[2];
    logic [15:0] m_d[2], m_rd[2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_act[i] <= 1'b0; m_rw[i] <= 1'b0; m_k[i] <= 0; m_blk[i] <= 0;
                m_a[i] <= '0; m_d[i] <= '0; m_rd[i] <= '0;
            end else if (m_act[i]) begin
                if (m_k[i] == ps[i] + pt[i] && !m_rw[i]) m_rd[i] <= din[i];
                if (m_k[i] == ps[i] + pt[i] + ph[i]) begin
                    m_act[i] <= 1'b0;
                    m_blk[i] <= pr[i];
                end else m_k[i] <= m_k[i] + 1;
            end else if (m_blk[i] > 0) m_blk[i] <= m_blk[i] - 1;
            else if (cs[i] && (rd[i] || wr[i])) begin
                m_act[i] <= 1'b1; m_k[i] <= 1; m_rw[i] <= wr[i];
                m_a[i] <= ad[i]; m_d[i] <= wd[i];
            end
        end
    end

    logic c_strb, c_done;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            c_strb = m_act[i] && m_k[i] > ps[i] && m_k[i] <= ps[i] + pt[i];
            c_done = m_act[i] && m_k[i] == ps[i] + pt[i] + ph[i];
            chk("cs_n", i, 16'(cs_n[i]), 16'(!m_act[i]));
            chk("rd_n", i, 16'(rd_n[i]), 16'(!(c_strb && !m_rw[i])));
            chk("wr_n", i, 16'(wr_n[i]), 16'(!(c_strb && m_rw[i])));
            chk("oe", i, 16'(oe[i]), 16'(m_act[i] && m_rw[i]));
            chk("addr", i, 16'(oa[i]), 16'(m_a[i]));
            chk("data_out", i, dout[i], m_d[i]);
            chk("readdata", i, rdata[i], m_rd[i]);
            chk("waitrequest", i, 16'(wt[i]), 16'(cs[i] && (rd[i] || wr[i]) && !c_done));
        end
    end

    logic        q_r[2], q_w[2];
    logic [1:0]  q_a[2];
    logic [15:0] q_d[2];
    logic        lg_cs[32], lg_rdn[32], lg_wrn[32], lg_wt[32], lg_oe[32];
    logic [1:0]  lg_a[32];
    logic [15:0] lg_do[32], lg_rd[32];

    // two requests issued back-to-back; cycle 0 is the first request cycle
    task automatic run_seq(input int i, input int ncyc, input int chg_at);
        int n = 0;
        logic w_s;
        @(posedge clk); #1;
        cs[i] = 1'b1; rd[i] = q_r[0]; wr[i] = q_w[0]; ad[i] = q_a[0]; wd[i] = q_d[0];
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            lg_cs[c] = cs_n[i]; lg_rdn[c] = rd_n[i]; lg_wrn[c] = wr_n[i]; lg_wt[c] = wt[i];
            lg_oe[c] = oe[i]; lg_a[c] = oa[i]; lg_do[c] = dout[i]; lg_rd[c] = rdata[i];
            w_s = wt[i];
            @(posedge clk); #1;
            if (c == chg_at) wd[i] = 16'hAAAA;
            if (cs[i] && !w_s) begin
                n++;
                if (n < 2) begin
                    rd[i] = q_r[n]; wr[i] = q_w[n]; ad[i] = q_a[n]; wd[i] = q_d[n];
                end else begin
                    cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
                end
            end
        end
    endtask

    // Avalon-compliant random master; entered and left just after a rising edge
    task automatic master(input int i, input int n);
        logic w_s;
        int k, cyc;
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            end
            k = $urandom_range(0, 3);
            cs[i] = 1'b1; rd[i] = (k != 2); wr[i] = (k >= 2);
            ad[i] = 2'($urandom_range(0, 3)); wd[i] = 16'($urandom);
            cyc = 0;
            do begin
                din[i] = 16'($urandom);
                @(negedge clk); w_s = wt[i];
                @(posedge clk); #1;
                cyc++;
                if (w_s && $urandom_range(0, 3) == 0) begin
                    ad[i] = 2'($urandom_range(0, 3)); wd[i] = 16'($urandom);
                end
            end while (w_s && cyc < 64);
            if (w_s) begin
                checks++; failures++;
                $display("FAIL timeout dut%0d waitrequest still high after %0d cycles", i, cyc);
            end
            cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0; din[i] = '0;
        end
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", i, 16'(cs_n[i]), 16'h1);
            chk("rst_rd_n", i, 16'(rd_n[i]), 16'h1);
            chk("rst_wr_n", i, 16'(wr_n[i]), 16'h1);
            chk("rst_oe", i, 16'(oe[i]), 16'h0);
            chk("rst_data_out", i, dout[i], 16'h0);
            chk("rst_readdata", i, rdata[i], 16'h0);
        end
        @(posedge clk); #1 reset_n = 1'b1;

        // default timing: write 0x1234 to ADDRESS, then an immediate read of DATA
        din[0] = 16'hBEEF;
        q_r[0] = 1'b0; q_w[0] = 1'b1; q_a[0] = 2'd2; q_d[0] = 16'h1234;
        q_r[1] = 1'b1; q_w[1] = 1'b0; q_a[1] = 2'd0; q_d[1] = 16'h0000;
        run_seq(0, 24, -1);
        chk("w_cs_n_c0", 0, 16'(lg_cs[0]), 16'h1);
        chk("w_wait_c0", 0, 16'(lg_wt[0]), 16'h1);
        chk("w_cs_n_c1", 0, 16'(lg_cs[1]), 16'h0);
        chk("w_addr_c1", 0, 16'(lg_a[1]), 16'h2);
        chk("w_oe_c1", 0, 16'(lg_oe[1]), 16'h1);
        chk("w_data_c1", 0, lg_do[1], 16'h1234);
        chk("w_wr_n_c2", 0, 16'(lg_wrn[2]), 16'h1);
        chk("w_wr_n_c3", 0, 16'(lg_wrn[3]), 16'h0);
        chk("w_wr_n_c6", 0, 16'(lg_wrn[6]), 16'h0);
        chk("w_wr_n_c7", 0, 16'(lg_wrn[7]), 16'h1);
        chk("w_rd_n_c4", 0, 16'(lg_rdn[4]), 16'h1);
        chk("w_wait_c7", 0, 16'(lg_wt[7]), 16'h1);
        chk("w_wait_c8", 0, 16'(lg_wt[8]), 16'h0);
        chk("w_cs_n_c8", 0, 16'(lg_cs[8]), 16'h0);
        chk("w_oe_c8", 0, 16'(lg_oe[8]), 16'h1);
        chk("w_cs_n_c9", 0, 16'(lg_cs[9]), 16'h1);
        chk("w_oe_c9", 0, 16'(lg_oe[9]), 16'h0);
        chk("b2b_wait_c11", 0, 16'(lg_wt[11]), 16'h1);
        chk("b2b_cs_n_c12", 0, 16'(lg_cs[12]), 16'h1);
        chk("r_cs_n_c13", 0, 16'(lg_cs[13]), 16'h0);
        chk("r_addr_c13", 0, 16'(lg_a[13]), 16'h0);
        chk("r_oe_c15", 0, 16'(lg_oe[15]), 16'h0);
        chk("r_rd_n_c15", 0, 16'(lg_rdn[15]), 16'h0);
        chk("r_rd_n_c18", 0, 16'(lg_rdn[18]), 16'h0);
        chk("r_rd_n_c19", 0, 16'(lg_rdn[19]), 16'h1);
        chk("r_wr_n_c16", 0, 16'(lg_wrn[16]), 16'h1);
        chk("r_wait_c19", 0, 16'(lg_wt[19]), 16'h1);
        chk("r_wait_c20", 0, 16'(lg_wt[20]), 16'h0);
        chk("r_readdata_c20", 0, lg_rd[20], 16'hBEEF);

        // minimum timing: write, then read&write together with writedata changed mid-access
        din[1] = 16'h0F0F;
        q_r[0] = 1'b0; q_w[0] = 1'b1; q_a[0] = 2'd1; q_d[0] = 16'h5A5A;
        q_r[1] = 1'b1; q_w[1] = 1'b1; q_a[1] = 2'd3; q_d[1] = 16'h00FF;
        run_seq(1, 10, 5);
        chk("m_cs_n_c1", 1, 16'(lg_cs[1]), 16'h0);
        chk("m_wr_n_c2", 1, 16'(lg_wrn[2]), 16'h0);
        chk("m_wait_c2", 1, 16'(lg_wt[2]), 16'h1);
        chk("m_wait_c3", 1, 16'(lg_wt[3]), 16'h0);
        chk("m_cs_n_c4", 1, 16'(lg_cs[4]), 16'h1);
        chk("m_cs_n_c5", 1, 16'(lg_cs[5]), 16'h0);
        chk("m_addr_c5", 1, 16'(lg_a[5]), 16'h3);
        chk("rw_wr_n_c6", 1, 16'(lg_wrn[6]), 16'h0);
        chk("rw_rd_n_c6", 1, 16'(lg_rdn[6]), 16'h1);
        chk("rw_oe_c6", 1, 16'(lg_oe[6]), 16'h1);
        chk("rw_data_c6", 1, lg_do[6], 16'h00FF);
        chk("rw_data_c7", 1, lg_do[7], 16'h00FF);
        chk("rw_wait_c7", 1, 16'(lg_wt[7]), 16'h0);
        chk("rw_readdata_c8", 1, lg_rd[8], 16'h0000);

        fork
            master(0, 120);
            master(1, 200);
        join

        // reset asserted mid-STROBE of a write
        repeat (6) begin @(posedge clk); #1; end
        cs[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b0; ad[0] = 2'd1; wd[0] = 16'h1357;
        repeat (5) @(negedge clk);
        chk("pre_rst_wr_n", 0, 16'(wr_n[0]), 16'h0);
        chk("pre_rst_cs_n", 0, 16'(cs_n[0]), 16'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs_n", 0, 16'(cs_n[0]), 16'h1);
        chk("arst_rd_n", 0, 16'(rd_n[0]), 16'h1);
        chk("arst_wr_n", 0, 16'(wr_n[0]), 16'h1);
        chk("arst_oe", 0, 16'(oe[0]), 16'h0);
        chk("arst_readdata", 0, rdata[0], 16'h0);
        @(posedge clk); #1;
        cs[0] = 1'b0; wr[0] = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_cs_n", 0, 16'(cs_n[0]), 16'h1);
        chk("post_rst_wait", 0, 16'(wt[0]), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
